binary_fc_seq_engine: RTL and testbench
=======================================

BINARY_FC_SEQ_ENGINE -- requirements
Module: binary_fc_seq_engine

Interface
REQ-001 Parameter IN_DIM, default 16, input vector length.
REQ-002 Parameter OUT_DIM, default 8, output neuron count.
REQ-003 Parameter BIT_CNT, default 8, unsigned input width and signed output width.
REQ-004 Parameter CH_CNT, default 8, binarization channels per input element; power of two, 2 to 2^BIT_CNT.
REQ-005 Parameter LANES, default 2, neurons computed per cycle; OUT_DIM divisible by LANES.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  input vector and weights offered.
REQ-009 in_ready  output  1  block can accept a vector.
REQ-010 value_in  input  [IN_DIM][BIT_CNT]  unsigned input elements.
REQ-011 weight  input  [OUT_DIM][IN_DIM]  binary weights; 1 = +1, 0 = -1.
REQ-012 sign_mode  input  1  0 = saturated sum output, 1 = sign-only output.
REQ-013 out_valid  output  1  value_out holds a complete result.
REQ-014 out_ready  input  1  consumer takes the result.
REQ-015 value_out  output  [OUT_DIM][BIT_CNT]  signed two's-complement results.
REQ-016 busy  output  1  high in COMPUTE or DONE.

Function
REQ-017 FSM states IDLE, COMPUTE and DONE; in_ready = (state == IDLE), derived combinationally.
REQ-018 IDLE: in_valid && in_ready at an edge registers the binarized channels, weight and sign_mode, clears group counter g, and enters COMPUTE.
REQ-019 Binarization: STEP = 2^BIT_CNT / CH_CNT; channel k = (value_in >= k*STEP + STEP/2), thermometer code.
REQ-020 Per element: contribution = sum over k of (weight XNOR channel_k ? +1 : -1), range [-CH_CNT, +CH_CNT].
REQ-021 Neuron sum: signed sum of IN_DIM contributions; ACC_W = clog2(IN_DIM*CH_CNT)+2 bits; no overflow is permitted.
REQ-022 COMPUTE: each cycle evaluates neurons g*LANES to g*LANES+LANES-1 and registers them into value_out; g then increments.
REQ-023 When g = OUT_DIM/LANES-1 is processed, the FSM enters DONE and out_valid rises; latency is exactly OUT_DIM/LANES edges after the accepting edge.
REQ-024 sign_mode=0: output = sum clamped to [-2^(BIT_CNT-1), 2^(BIT_CNT-1)-1].
REQ-025 sign_mode=1: output = +1 if sum >= 0, else -1 (all ones).
REQ-026 DONE: value_out and out_valid stay stable until out_valid && out_ready; that edge returns the FSM to IDLE and clears out_valid.
REQ-027 in_valid is ignored outside IDLE; registered inputs are not altered by input-port changes during COMPUTE or DONE.
REQ-028 Minimum issue interval is OUT_DIM/LANES+2 cycles per vector; there is no result/accept overlap.
REQ-029 value_out is updated only in COMPUTE; in IDLE it holds the last result.

Reset
REQ-030 rst at any edge forces IDLE, g=0, out_valid=0, busy=0, value_out=0, and clears the registered channels, weights and sign_mode; in_ready=1 after the reset edge.
REQ-031 Reset during COMPUTE or DONE aborts the vector; no out_valid is produced for it.

Structure
REQ-032 Shared package binary_nn_pkg holds the state enum typedef and a saturation function parametrised on widths.
REQ-033 ACC_W, STEP and group count are module localparams derived from the parameters.
REQ-034 One sub-module, thermo_binarizer (params IN_CNT, IN_BIT, CH_CNT), implements REQ-019 combinationally; the popcount/accumulate logic stays in this module.

Verification (IN_DIM=4, OUT_DIM=4, BIT_CNT=8, CH_CNT=4, LANES=2 unless stated)
REQ-035 value_in all 255, weights all 1, sign_mode=0 -> out_valid 2 edges after accept, each value_out = 16.
REQ-036 value_in all 255, weights all 0, sign_mode=0 -> each value_out = -16 (8'hF0); with value_in all 100, weights 1, sign_mode=1 -> sums 0, each output +1.
REQ-037 IN_DIM=16, CH_CNT=16, value_in all 255, weights 1 and 0 per neuron, sign_mode=0 -> outputs 127 and -128 (saturated).
REQ-038 out_ready held low 5 cycles after out_valid -> value_out and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-039 rst asserted in the second COMPUTE cycle -> out_valid never rises for that vector, in_ready=1 after the reset edge, and the next vector returns the correct result.
REQ-040 Back-to-back vectors with in_valid held high -> accepts spaced exactly 4 cycles apart (out_ready=1), each result matching a reference model.

Source files
------------

// File: rtl/binary_nn_pkg.sv
// Shared types and helpers for the binarized neural-network datapath blocks.
//   fsm_state_t : IDLE / COMPUTE / DONE sequencing states
//   sat_signed  : clamps a signed value into a signed range out_w bits wide
package binary_nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } fsm_state_t;

  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                   input int unsigned      out_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (out_w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/thermo_binarizer.sv
// Thermometer binarizer: each unsigned element is compared against CH_CNT
// evenly spaced thresholds placed at the centre of each quantization step.
//   value_in : IN_CNT unsigned elements, IN_BIT bits each
//   ch       : IN_CNT x CH_CNT channel bits, ch[i][k] = value_in[i] >= k*STEP + STEP/2
module thermo_binarizer #(
  parameter int IN_CNT = 16,
  parameter int IN_BIT = 8,
  parameter int CH_CNT = 8
) (
  input  logic [IN_CNT-1:0][IN_BIT-1:0] value_in,
  output logic [IN_CNT-1:0][CH_CNT-1:0] ch
);

  localparam int STEP = (1 << IN_BIT) / CH_CNT;

  for (genvar i = 0; i < IN_CNT; i++) begin : g_elem
    for (genvar k = 0; k < CH_CNT; k++) begin : g_ch
      // One extra bit so the largest threshold never wraps.
      localparam int THR = k * STEP + STEP / 2;
      assign ch[i][k] = ({1'b0, value_in[i]} >= (IN_BIT + 1)'(THR));
    end
  end

endmodule

// File: rtl/binary_fc_seq_engine.sv
// Sequential binary fully-connected layer. An accepted vector is binarized
// into thermometer channels and latched with its weights; LANES neurons are
// then evaluated per cycle as XNOR-popcount sums and written to value_out,
// either saturated to BIT_CNT bits or reduced to +1/-1.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : input handshake (ready only in IDLE)
//   value_in, weight    : unsigned elements, binary weights (1 = +1, 0 = -1)
//   sign_mode           : 0 = saturated sum, 1 = sign only
//   out_valid/out_ready : result handshake, result held until taken
//   value_out           : signed two's-complement neuron outputs
//   busy                : high while computing or holding a result
module binary_fc_seq_engine
  import binary_nn_pkg::*;
#(
  parameter int IN_DIM  = 16,
  parameter int OUT_DIM = 8,
  parameter int BIT_CNT = 8,
  parameter int CH_CNT  = 8,
  parameter int LANES   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_DIM-1:0][BIT_CNT-1:0]    value_in,
  input  logic [OUT_DIM-1:0][IN_DIM-1:0]    weight,
  input  logic                              sign_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_DIM-1:0][BIT_CNT-1:0]   value_out,
  output logic                              busy
);

  localparam int ACC_W  = $clog2(IN_DIM * CH_CNT) + 2;
  localparam int STEP   = (1 << BIT_CNT) / CH_CNT;
  localparam int GROUPS = OUT_DIM / LANES;
  localparam int G_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int N_W    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [G_W-1:0] G_LAST = G_W'(GROUPS - 1);

  // CH_CNT above 2^BIT_CNT leaves no room for a threshold step.
  if (STEP == 0) begin : g_illegal_ch_cnt
  end

  fsm_state_t                       state;
  logic [G_W-1:0]                   g_p0;
  logic [IN_DIM-1:0][CH_CNT-1:0]    ch_in;
  logic [IN_DIM-1:0][CH_CNT-1:0]    ch_p0;
  logic [OUT_DIM-1:0][IN_DIM-1:0]   weight_p0;
  logic                             mode_p0;

  logic [LANES-1:0][N_W-1:0]        lane_idx;
  logic [LANES-1:0][BIT_CNT-1:0]    lane_res;
  logic [ACC_W-1:0]                 pop_acc;
  logic signed [ACC_W-1:0]          sum_acc;

  thermo_binarizer #(
    .IN_CNT (IN_DIM),
    .IN_BIT (BIT_CNT),
    .CH_CNT (CH_CNT)
  ) u_binarizer (
    .value_in (value_in),
    .ch       (ch_in)
  );

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  // Stage p0 -> output: XNOR-popcount of the latched channels for the current group.
  // Each +1/-1 term gives sum = 2*matches - IN_DIM*CH_CNT; modular ACC_W
  // arithmetic is exact because the true sum fits in ACC_W signed bits.
  always_comb begin
    lane_idx = '0;
    lane_res = '0;
    pop_acc  = '0;
    sum_acc  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = N_W'(int'(g_p0) * LANES + l);
      pop_acc = '0;
      for (int i = 0; i < IN_DIM; i++) begin
        for (int k = 0; k < CH_CNT; k++) begin
          pop_acc = pop_acc + ACC_W'(weight_p0[lane_idx[l]][i] ~^ ch_p0[i][k]);
        end
      end
      sum_acc = signed'((pop_acc << 1) - ACC_W'(IN_DIM * CH_CNT));
      if (mode_p0) begin
        lane_res[l] = sum_acc[ACC_W-1] ? '1 : BIT_CNT'(1);
      end else begin
        lane_res[l] = BIT_CNT'(sat_signed(32'(sum_acc), BIT_CNT));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      g_p0      <= '0;
      out_valid <= 1'b0;
      value_out <= '0;
      ch_p0     <= '0;
      weight_p0 <= '0;
      mode_p0   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Stage input -> p0: latch binarized channels, weights and mode.
          if (in_valid) begin
            ch_p0     <= ch_in;
            weight_p0 <= weight;
            mode_p0   <= sign_mode;
            g_p0      <= '0;
            state     <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          for (int l = 0; l < LANES; l++) begin
            value_out[lane_idx[l]] <= lane_res[l];
          end
          if (g_p0 == G_LAST) begin
            g_p0      <= '0;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            g_p0 <= g_p0 + G_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binary_fc_seq_engine.sv
module tb_binary_fc_seq_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: IN_DIM=4, OUT_DIM=4, BIT_CNT=8, CH_CNT=4, LANES=2
  logic             in_valid, in_ready, sign_mode, out_valid, out_ready, busy;
  logic [3:0][7:0]  value_in;
  logic [3:0][3:0]  weight;
  logic [3:0][7:0]  value_out;

  // Instance B: IN_DIM=16, OUT_DIM=4, BIT_CNT=8, CH_CNT=16, LANES=2
  logic             in_valid_b, in_ready_b, sign_mode_b, out_valid_b, out_ready_b, busy_b;
  logic [15:0][7:0] value_in_b;
  logic [3:0][15:0] weight_b;
  logic [3:0][7:0]  value_out_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  binary_fc_seq_engine #(
    .IN_DIM(4), .OUT_DIM(4), .BIT_CNT(8), .CH_CNT(4), .LANES(2)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .value_in(value_in), .weight(weight), .sign_mode(sign_mode),
    .out_valid(out_valid), .out_ready(out_ready), .value_out(value_out), .busy(busy)
  );

  binary_fc_seq_engine #(
    .IN_DIM(16), .OUT_DIM(4), .BIT_CNT(8), .CH_CNT(16), .LANES(2)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .value_in(value_in_b), .weight(weight_b), .sign_mode(sign_mode_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .value_out(value_out_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: count thermometer channels per element (thresholds 32,96,160,224),
  // each element adds +(2c-4) for weight 1 or -(2c-4) for weight 0.
  function automatic logic [3:0][7:0] ref_vec(input logic [3:0][7:0] v,
                                              input logic [3:0][3:0] w,
                                              input logic m);
    logic [3:0][7:0] r;
    for (int n = 0; n < 4; n++) begin
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) begin
        int c;
        c = 0;
        for (int k = 0; k < 4; k++) if (int'(v[i]) >= k * 64 + 32) c++;
        if (w[n][i]) s += 2 * c - 4;
        else         s += 4 - 2 * c;
      end
      if (m)             r[n] = (s >= 0) ? 8'd1 : 8'hFF;
      else if (s > 127)  r[n] = 8'd127;
      else if (s < -128) r[n] = 8'h80;
      else               r[n] = 8'(s);
    end
    return r;
  endfunction

  task automatic rand_vec(output logic [3:0][7:0] v, output logic [3:0][3:0] w, output logic m);
    for (int i = 0; i < 4; i++) v[i] = 8'($urandom);
    w = 16'($urandom);
    m = 1'($urandom_range(0, 1));
  endtask

  task automatic send_and_wait(input logic [3:0][7:0] v, input logic [3:0][3:0] w,
                               input logic m, output int lat);
    in_valid  = 1'b1;
    value_in  = v;
    weight    = w;
    sign_mode = m;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL reset_ctrl got rdy=%b ov=%b busy=%b exp 1 0 0", in_ready, out_valid, busy); end
    checks++;
    if (value_out !== 32'h0)
      begin failures++; $display("FAIL reset_value_out got=%h exp=00000000", value_out); end
    rst = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL reset_release got rdy=%b busy=%b exp 1 0", in_ready, busy); end
  endtask

  task automatic test_basic();
    int lat;
    send_and_wait({4{8'hFF}}, {4{4'hF}}, 1'b0, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0)
      begin failures++; $display("FAIL basic_done_flags got busy=%b rdy=%b exp 1 0", busy, in_ready); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (value_out[n] !== 8'd16)
        begin failures++; $display("FAIL basic_out[%0d] got=%h exp=10", n, value_out[n]); end
    end
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin failures++; $display("FAIL basic_release got rdy=%b ov=%b exp 1 0", in_ready, out_valid); end
  endtask

  task automatic test_negative_and_sign();
    int lat;
    send_and_wait({4{8'hFF}}, 16'h0000, 1'b0, lat);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (value_out[n] !== 8'hF0)
        begin failures++; $display("FAIL neg_out[%0d] got=%h exp=f0", n, value_out[n]); end
    end
    release_result();
    send_and_wait({4{8'd100}}, {4{4'hF}}, 1'b1, lat);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (value_out[n] !== 8'd1)
        begin failures++; $display("FAIL sign_zero_out[%0d] got=%h exp=01", n, value_out[n]); end
    end
    release_result();
  endtask

  task automatic test_saturate();
    int lat;
    checks++;
    if (in_ready_b !== 1'b1)
      begin failures++; $display("FAIL sat_ready got=%b exp=1", in_ready_b); end
    in_valid_b  = 1'b1;
    value_in_b  = {16{8'hFF}};
    weight_b    = {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    sign_mode_b = 1'b0;
    step();
    in_valid_b = 1'b0;
    lat = 0;
    while (!out_valid_b && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 2 || busy_b !== 1'b1)
      begin failures++; $display("FAIL sat_latency got=%0d busy=%b exp=2 1", lat, busy_b); end
    for (int n = 0; n < 4; n++) begin
      logic [7:0] e;
      e = (n % 2 == 0) ? 8'h7F : 8'h80;
      checks++;
      if (value_out_b[n] !== e)
        begin failures++; $display("FAIL sat_out[%0d] got=%h exp=%h", n, value_out_b[n], e); end
    end
    out_ready_b = 1'b1;
    step();
    out_ready_b = 1'b0;
  endtask

  task automatic test_stall();
    logic [3:0][7:0] v, exp;
    logic [3:0][3:0] w;
    logic m;
    int lat;
    rand_vec(v, w, m);
    exp = ref_vec(v, w, m);
    send_and_wait(v, w, m, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid  = 1'b1;
      value_in  = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      weight    = 16'($urandom);
      sign_mode = ~m;
      step();
      checks++;
      if (value_out !== exp || out_valid !== 1'b1 || in_ready !== 1'b0)
        begin failures++; $display("FAIL stall_hold[%0d] got=%h ov=%b rdy=%b exp=%h 1 0", c, value_out, out_valid, in_ready, exp); end
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || value_out !== exp)
      begin failures++; $display("FAIL stall_release got rdy=%b ov=%b val=%h exp 1 0 %h", in_ready, out_valid, value_out, exp); end
  endtask

  task automatic test_reset_mid();
    logic [3:0][7:0] v, exp;
    logic [3:0][3:0] w;
    logic m;
    logic seen;
    int lat;
    rand_vec(v, w, m);
    in_valid = 1'b1; value_in = v; weight = w; sign_mode = m;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || value_out !== 32'h0)
      begin failures++; $display("FAIL midreset_state got rdy=%b ov=%b busy=%b val=%h exp 1 0 0 0", in_ready, out_valid, busy, value_out); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_valid got=%b exp=0", seen); end
    rand_vec(v, w, m);
    exp = ref_vec(v, w, m);
    send_and_wait(v, w, m, lat);
    checks++;
    if (lat !== 2 || value_out !== exp)
      begin failures++; $display("FAIL midreset_next got lat=%0d val=%h exp 2 %h", lat, value_out, exp); end
    release_result();
  endtask

  task automatic test_random();
    logic [3:0][7:0] v, exp;
    logic [3:0][3:0] w;
    logic m;
    int lat;
    for (int t = 0; t < 12; t++) begin
      rand_vec(v, w, m);
      exp = ref_vec(v, w, m);
      send_and_wait(v, w, m, lat);
      checks++;
      if (lat !== 2 || value_out !== exp)
        begin failures++; $display("FAIL random[%0d] got lat=%0d val=%h exp 2 %h (v=%h w=%h m=%b)", t, lat, value_out, exp, v, w, m); end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] e;
    logic [3:0][7:0] v;
    logic [3:0][3:0] w;
    logic m, acc;
    int accepts, last, guard;
    accepts = 0; last = -1; guard = 0;
    rand_vec(v, w, m);
    value_in = v; weight = w; sign_mode = m;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while ((accepts < 6 || q.size() > 0) && guard < 200) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_extra got=%h exp=none", value_out);
        end else begin
          e = q.pop_front();
          if (value_out !== e) begin failures++; $display("FAIL b2b_result got=%h exp=%h", value_out, e); end
        end
      end
      acc = in_valid && in_ready;
      step();
      guard++;
      if (acc) begin
        q.push_back(ref_vec(v, w, m));
        if (last >= 0) begin
          checks++;
          if (cyc - last != 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", cyc - last); end
        end
        last = cyc;
        accepts++;
        if (accepts < 6) begin
          rand_vec(v, w, m);
          value_in = v; weight = w; sign_mode = m;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (accepts != 6 || q.size() != 0)
      begin failures++; $display("FAIL b2b_timeout got accepts=%0d pending=%0d exp 6 0", accepts, q.size()); end
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; value_in = '0; weight = '0; sign_mode = 1'b0; out_ready = 1'b0;
    in_valid_b = 1'b0; value_in_b = '0; weight_b = '0; sign_mode_b = 1'b0; out_ready_b = 1'b0;
    test_reset();
    test_basic();
    test_negative_and_sign();
    test_saturate();
    test_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
